// File: rtl/join_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : join_pkg                                                          |
// | Brief  : Shared lane indices, drop-counter width and saturating adder.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package join_pkg;

  localparam int NUM_LANES      = 4;
  localparam int LANE_A         = 0;
  localparam int LANE_B         = 1;
  localparam int LANE_C         = 2;
  localparam int LANE_D         = 3;
  localparam int DROP_CNT_WIDTH = 16;

  // Adds up to 4 drops per cycle and sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_add(
    input logic [DROP_CNT_WIDTH-1:0] base,
    input logic [2:0]                inc
  );
    logic [DROP_CNT_WIDTH:0] sum;
    sum = {1'b0, base} + {{(DROP_CNT_WIDTH-2){1'b0}}, inc};
    return sum[DROP_CNT_WIDTH] ? {DROP_CNT_WIDTH{1'b1}} : sum[DROP_CNT_WIDTH-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : lane_fifo                                                         |
// | Brief  : Single-lane FIFO with wrap-bit pointers; async active-low reset.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lane_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  artsn_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int c_AW = $clog2(FIFO_DEPTH);

  logic [c_AW:0]           r_wr_ptr;
  logic [c_AW:0]           r_rd_ptr;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];

  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_i) r_wr_ptr <= r_wr_ptr + {{c_AW{1'b0}}, 1'b1};
      if (rd_i) r_rd_ptr <= r_rd_ptr + {{c_AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk_i) begin
    if (wr_i) r_mem[r_wr_ptr[c_AW-1:0]] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr[c_AW-1:0]];
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/operand_join.sv
// +----------------------------------------------------------------------------+
// | Module : operand_join                                                      |
// | Brief  : Aligns four skewed operand lanes into tuples; optional drop       |
// |          counter enabled by macro JOIN_DROP_CNT_EN.                        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module operand_join
  import join_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  artsn_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  input  logic                  a_valid_i,
  input  logic                  b_valid_i,
  input  logic                  c_valid_i,
  input  logic                  d_valid_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [DATA_WIDTH-1:0] c_o,
  output logic [DATA_WIDTH-1:0] d_o,
  output logic                  valid_o,
  output logic [NUM_LANES-1:0]  ovf_o
`ifdef JOIN_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
`endif
);

  logic [DATA_WIDTH-1:0] w_in_data [NUM_LANES];
  logic [DATA_WIDTH-1:0] w_head    [NUM_LANES];
  logic [NUM_LANES-1:0]  w_in_vld;
  logic [NUM_LANES-1:0]  w_empty;
  logic [NUM_LANES-1:0]  w_full;
  logic [NUM_LANES-1:0]  w_push;
  logic [NUM_LANES-1:0]  w_drop;
  logic                  w_launch;

  logic [DATA_WIDTH-1:0] r_out [NUM_LANES];
  logic                  r_valid;
  logic [NUM_LANES-1:0]  r_ovf;

  assign w_in_data[LANE_A] = a_i;
  assign w_in_data[LANE_B] = b_i;
  assign w_in_data[LANE_C] = c_i;
  assign w_in_data[LANE_D] = d_i;
  assign w_in_vld = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};

  assign w_launch = ~|w_empty;
  // A full lane still accepts when the same-cycle launch frees its head slot.
  assign w_push   = w_in_vld & (~w_full | {NUM_LANES{w_launch}});
  assign w_drop   = w_in_vld & w_full & {NUM_LANES{~w_launch}};

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk_i   (clk_i),
        .artsn_i (artsn_i),
        .wr_i    (w_push[i]),
        .data_i  (w_in_data[i]),
        .rd_i    (w_launch),
        .data_o  (w_head[i]),
        .empty_o (w_empty[i]),
        .full_o  (w_full[i])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      for (int i = 0; i < NUM_LANES; i++) r_out[i] <= '0;
      r_valid <= 1'b0;
      r_ovf   <= '0;
    end else begin
      r_valid <= w_launch;
      r_ovf   <= r_ovf | w_drop;
      if (w_launch) begin
        for (int i = 0; i < NUM_LANES; i++) r_out[i] <= w_head[i];
      end
    end
  end

  assign a_o     = r_out[LANE_A];
  assign b_o     = r_out[LANE_B];
  assign c_o     = r_out[LANE_C];
  assign d_o     = r_out[LANE_D];
  assign valid_o = r_valid;
  assign ovf_o   = r_ovf;

`ifdef JOIN_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
  logic [2:0]                w_drop_num;

  assign w_drop_num = {2'b00, w_drop[LANE_A]} + {2'b00, w_drop[LANE_B]} +
                      {2'b00, w_drop[LANE_C]} + {2'b00, w_drop[LANE_D]};

  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) r_drop_cnt <= '0;
    else          r_drop_cnt <= sat_add(r_drop_cnt, w_drop_num);
  end

  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

`default_nettype wire
